// File: rtl/pe_types.sv
// -----------------------------------------------------------------------------
// pe_types
//   Shared types for the processing-element datapath.
//   - pe_cfg_t     : static configuration of a dot-product array.
//   - seq_state_t  : state encoding of the dot-product job sequencer.
//   - Dly*         : bit positions of the sequencer's delay-line payload.
//   - credit_cnt_width() : width needed to hold a credit count 0..credits.
// -----------------------------------------------------------------------------
package pe_types;

    // Static dot-array configuration. DOT_LATENCY is the number of cycles from
    // presenting a block to the array until its registered dot result appears.
    typedef struct packed {
        int unsigned DOT_SIZE;
        int unsigned DOT_LATENCY;
    } pe_cfg_t;

    localparam pe_cfg_t PeCfgDefault = '{DOT_SIZE: 32'd8, DOT_LATENCY: 32'd4};

    // Sequencer states.
    typedef enum logic [1:0] {
        SeqIdle       = 2'd0,
        SeqWaitCredit = 2'd1,
        SeqRun        = 2'd2
    } seq_state_t;

    // Per-block tag travelling alongside the dot array.
    localparam int unsigned DlyValid = 0;  // block issued
    localparam int unsigned DlyFirst = 1;  // block 0 of a job: accumulator loads
    localparam int unsigned DlyLast  = 2;  // final block of a job
    localparam int unsigned DlyWidth = 3;

    function automatic int unsigned credit_cnt_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/pe_dot_seq_delay.sv
// -----------------------------------------------------------------------------
// pe_dot_seq_delay
//   Fixed-depth shift register that delays a tag vector by Depth cycles so it
//   lines up with the dot-array output. Depth 0 degenerates to a wire.
//
// Parameters
//   Width      : tag width in bits.
//   Depth      : delay in clock cycles (0 = combinational pass-through).
// Ports
//   clk_i      : clock.
//   rst_ni     : asynchronous active-low reset; clears every stage.
//   d_i        : tag entering the line.
//   q_o        : tag leaving the line, Depth cycles later.
//   occupied_o : high while any stage holds a non-zero tag.
// -----------------------------------------------------------------------------
module pe_dot_seq_delay #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o,
    output logic             occupied_o
);

    generate
        if (Depth == 0) begin : g_wire
            assign q_o        = d_i;
            assign occupied_o = 1'b0;
        end else begin : g_shift
            logic [Width-1:0] stage_q [Depth];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int unsigned i = 0; i < Depth; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int unsigned i = 1; i < Depth; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            always_comb begin
                occupied_o = 1'b0;
                for (int unsigned i = 0; i < Depth; i++) begin
                    occupied_o = occupied_o | (|stage_q[i]);
                end
            end

            assign q_o = stage_q[Depth-1];
        end
    endgenerate

endmodule

// File: rtl/pe_dot_sequencer.sv
// -----------------------------------------------------------------------------
// pe_dot_sequencer
//   Issues the feature/filter blocks of a dot-product job into a pipelined dot
//   array and produces the matching accumulator controls and a result strobe.
//   A job of N blocks (N = 0 treated as 1) is issued on N consecutive cycles
//   with no stall; a job is only started when a downstream result-buffer
//   credit is available, so results can never overflow the buffer.
//
// Parameters
//   DOT_LATENCY : cycles from dot-array input to registered dot result.
//   STEP_W      : width of the step count and the block address.
//   OUT_CREDITS : depth of the downstream result buffer (1..15).
// Ports
//   clock, resetn     : clock and asynchronous active-low reset.
//   i_job_valid       : job request.
//   o_job_ready       : job accepted when high together with i_job_valid.
//   i_job_steps       : blocks per result.
//   o_rd_valid        : issue one block into the dot array.
//   o_rd_addr         : block index within the job.
//   o_acc_en          : accumulate the dot output (issue delayed DOT_LATENCY).
//   o_acc_clear       : first block of a job reaching the accumulator.
//   o_result_valid    : one-cycle pulse when a job's result is complete.
//   i_credit_return   : downstream popped one result.
//   o_busy            : job pending/running or blocks still in flight.
//   o_perf_busy_cycles, o_perf_wait_cycles : saturating performance counters,
//                       present only when PE_DOT_SEQ_PERF_EN is defined.
// -----------------------------------------------------------------------------
module pe_dot_sequencer
    import pe_types::*;
#(
    parameter int unsigned DOT_LATENCY = 4,
    parameter int unsigned STEP_W      = 16,
    parameter int unsigned OUT_CREDITS = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_job_valid,
    output logic              o_job_ready,
    input  logic [STEP_W-1:0] i_job_steps,
    output logic              o_rd_valid,
    output logic [STEP_W-1:0] o_rd_addr,
    output logic              o_acc_en,
    output logic              o_acc_clear,
    output logic              o_result_valid,
    input  logic              i_credit_return,
    output logic              o_busy
`ifdef PE_DOT_SEQ_PERF_EN
    ,
    output logic [31:0]       o_perf_busy_cycles,
    output logic [31:0]       o_perf_wait_cycles
`endif
);

    localparam int unsigned         CreditW   = credit_cnt_width(OUT_CREDITS);
    localparam logic [CreditW-1:0]  CreditMax = CreditW'(OUT_CREDITS);

    seq_state_t          state_q, state_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [STEP_W-1:0]   addr_q, addr_d;
    logic [CreditW-1:0]  credits_q, credits_d;
    logic                result_valid_q;

    logic                issue;
    logic                last_block;
    logic                accept;
    logic                credit_avail;
    logic                consume;
    logic [STEP_W-1:0]   job_steps_eff;
    logic [DlyWidth-1:0] dly_in, dly_out;
    logic                dly_occupied;

    assign job_steps_eff = (i_job_steps == '0) ? STEP_W'(1) : i_job_steps;
    assign issue         = (state_q == SeqRun);
    assign last_block    = issue && (addr_q == (steps_q - STEP_W'(1)));

    // A credit returned this cycle can be spent this cycle, so a job held for
    // lack of credit issues on the cycle right after the return.
    assign credit_avail  = (credits_q != '0) || i_credit_return;

    // Gated by resetn so ready is low while reset is held.
    assign o_job_ready   = resetn && ((state_q == SeqIdle) || last_block);
    assign accept        = i_job_valid && o_job_ready;

    // -------------------------------------------------------------------------
    // Job FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        addr_d  = addr_q;
        consume = 1'b0;

        case (state_q)
            SeqIdle: begin
                if (accept) begin
                    steps_d = job_steps_eff;
                    addr_d  = '0;
                    if (credit_avail) begin
                        state_d = SeqRun;
                        consume = 1'b1;
                    end else begin
                        state_d = SeqWaitCredit;
                    end
                end
            end

            SeqWaitCredit: begin
                if (credit_avail) begin
                    state_d = SeqRun;
                    consume = 1'b1;
                end
            end

            SeqRun: begin
                if (last_block) begin
                    addr_d = '0;
                    if (accept) begin
                        // Back-to-back job: no bubble when a credit is ready.
                        steps_d = job_steps_eff;
                        if (credit_avail) begin
                            state_d = SeqRun;
                            consume = 1'b1;
                        end else begin
                            state_d = SeqWaitCredit;
                        end
                    end else begin
                        state_d = SeqIdle;
                    end
                end else begin
                    addr_d = addr_q + STEP_W'(1);
                end
            end

            default: begin
                state_d = SeqIdle;
                addr_d  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Credit counter: one credit per started job, saturating at OUT_CREDITS.
    // consume with an empty counter only happens alongside a return, which
    // falls into the net-unchanged case.
    // -------------------------------------------------------------------------
    always_comb begin
        credits_d = credits_q;
        case ({consume, i_credit_return})
            2'b10: credits_d = credits_q - CreditW'(1);
            2'b01: begin
                if (credits_q != CreditMax) begin
                    credits_d = credits_q + CreditW'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= SeqIdle;
            steps_q   <= STEP_W'(1);
            addr_q    <= '0;
            credits_q <= CreditMax;
        end else begin
            state_q   <= state_d;
            steps_q   <= steps_d;
            addr_q    <= addr_d;
            credits_q <= credits_d;
        end
    end

    // -------------------------------------------------------------------------
    // Tag delay line aligned with the dot array, plus one stage for the
    // accumulator to register the final sum.
    // -------------------------------------------------------------------------
    always_comb begin
        dly_in           = '0;
        dly_in[DlyValid] = issue;
        dly_in[DlyFirst] = issue && (addr_q == '0);
        dly_in[DlyLast]  = last_block;
    end

    pe_dot_seq_delay #(
        .Width (DlyWidth),
        .Depth (DOT_LATENCY)
    ) u_delay (
        .clk_i      (clock),
        .rst_ni     (resetn),
        .d_i        (dly_in),
        .q_o        (dly_out),
        .occupied_o (dly_occupied)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= dly_out[DlyValid] && dly_out[DlyLast];
        end
    end

    assign o_rd_valid     = issue;
    assign o_rd_addr      = addr_q;
    assign o_acc_en       = dly_out[DlyValid];
    assign o_acc_clear    = dly_out[DlyFirst];
    assign o_result_valid = result_valid_q;
    assign o_busy         = (state_q != SeqIdle) || dly_occupied || result_valid_q;

`ifdef PE_DOT_SEQ_PERF_EN
    // -------------------------------------------------------------------------
    // Saturating performance counters.
    // -------------------------------------------------------------------------
    logic [31:0] perf_busy_q;
    logic [31:0] perf_wait_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_busy_q <= '0;
            perf_wait_q <= '0;
        end else begin
            if (o_busy && (perf_busy_q != 32'hFFFF_FFFF)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if ((state_q == SeqWaitCredit) && (perf_wait_q != 32'hFFFF_FFFF)) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign o_perf_busy_cycles = perf_busy_q;
    assign o_perf_wait_cycles = perf_wait_q;
`endif

endmodule
